multi_line_buffer: RTL and testbench

Parametrised sliding-window line buffer for the streaming image pipeline. It replaces single-line FIFO cascades. Raster pixels go in; each accepted pixel produces one vertically aligned column of `ROWS` pixels (current pixel plus the pixels directly above it in the previous `ROWS-1` lines). It sits directly ahead of the window/convolution stage. It adds frame restart, column index and end-of-line outputs, and explicit priming control.

---
 rtl/line_buf_pkg.sv | 20 ++
 rtl/line_ram.sv | 34 +++
 rtl/multi_line_buffer.sv | 105 ++++++++++
 tb/tb_multi_line_buffer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/line_buf_pkg.sv
// rtl/line_buf_pkg.sv - shared width helpers and column view type for line buffer blocks
package line_buf_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_ROWS  = 3;

    // Packed column at the default geometry; slice 0 is the newest line.
    typedef logic [DEF_ROWS-1:0][DEF_WIDTH-1:0] pix_col_t;

    // Width of a counter that must be able to hold the value depth.
    function automatic int cnt_w(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

    // Width of an address into a memory with depth entries.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/line_ram.sv
// rtl/line_ram.sv - single-port line memory, read-before-write, registered read
module line_ram
    import line_buf_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 6,
    localparam int AW    = addr_w(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else if (en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/multi_line_buffer.sv
// rtl/multi_line_buffer.sv - sliding-window line buffer producing ROWS-pixel columns
module multi_line_buffer
    import line_buf_pkg::*;
#(
    parameter  int WIDTH     = 8,
    parameter  int IMG_WIDTH = 6,
    parameter  int ROWS      = 3,
    localparam int CNT_W     = cnt_w(IMG_WIDTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      in_din,
    input  logic                  valid_in,
    input  logic                  in_sof,
    output logic [ROWS*WIDTH-1:0] out_dout,
    output logic                  valid_out,
    output logic [CNT_W-1:0]      out_col,
    output logic                  out_eol
);

    localparam int NL    = ROWS - 1;
    localparam int SEL_W = cnt_w(NL);
    localparam int ROW_W = cnt_w(ROWS - 1);
    localparam int AW    = addr_w(IMG_WIDTH);

    logic [CNT_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [SEL_W-1:0] wsel;
    logic [SEL_W-1:0] wsel_d;
    logic [WIDTH-1:0] din_d;
    logic [WIDTH-1:0] rd [NL];

    logic [CNT_W-1:0] eff_col;
    logic [ROW_W-1:0] eff_row;
    logic             wrap;
    logic             primed;

    // A start-of-frame pixel is treated as row 0, col 0 regardless of counter state.
    always_comb begin
        eff_col = in_sof ? '0 : col;
        eff_row = in_sof ? '0 : row;
        wrap    = (eff_col == CNT_W'(IMG_WIDTH - 1));
        primed  = (eff_row == ROW_W'(ROWS - 1));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            col       <= '0;
            row       <= '0;
            wsel      <= '0;
            wsel_d    <= '0;
            din_d     <= '0;
            valid_out <= 1'b0;
            out_col   <= '0;
            out_eol   <= 1'b0;
        end else begin
            valid_out <= valid_in && primed;
            if (valid_in) begin
                din_d   <= in_din;
                wsel_d  <= wsel;
                out_col <= eff_col;
                out_eol <= wrap;
                if (wrap) begin
                    col  <= '0;
                    row  <= primed ? eff_row : eff_row + 1'b1;
                    wsel <= (wsel == SEL_W'(NL - 1)) ? '0 : wsel + 1'b1;
                end else begin
                    col  <= eff_col + 1'b1;
                    row  <= eff_row;
                end
            end
        end
    end

    // The vertical shift is done by rotating roles: the memory holding the oldest
    // line takes the incoming line, so each memory sees one write per pixel at most.
    for (genvar i = 0; i < NL; i++) begin : g_line
        line_ram #(
            .WIDTH (WIDTH),
            .DEPTH (IMG_WIDTH)
        ) u_ram (
            .clock (clock),
            .reset (reset),
            .en    (valid_in),
            .we    (wsel == SEL_W'(i)),
            .addr  (eff_col[AW-1:0]),
            .wdata (in_din),
            .rdata (rd[i])
        );
    end

    // Line of age a (1 = previous line) lives in memory i where wsel_d == (i + a) mod NL.
    always_comb begin
        out_dout = '0;
        out_dout[WIDTH-1:0] = din_d;
        for (int a = 1; a <= NL; a++) begin
            for (int i = 0; i < NL; i++) begin
                if (int'(wsel_d) == (i + a) % NL) begin
                    out_dout[a*WIDTH +: WIDTH] = rd[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_line_buffer.sv
// tb/tb_multi_line_buffer.sv - directed self-checking bench for multi_line_buffer
module tb_multi_line_buffer;
    import line_buf_pkg::*;

    localparam int IMG_WIDTH = 6;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  in_din = '0;
    logic        valid_in = 1'b0;
    logic        in_sof = 1'b0;
    logic [23:0] out_dout;
    logic        valid_out;
    logic [2:0]  out_col;
    logic        out_eol;

    logic [7:0]  b_din = '0;
    logic        b_valid = 1'b0;
    logic        b_sof = 1'b0;
    logic [15:0] b_dout;
    logic        b_vout;
    logic [0:0]  b_col;
    logic        b_eol;

    int checks = 0;
    int errors = 0;

    multi_line_buffer #(.WIDTH(8), .IMG_WIDTH(IMG_WIDTH), .ROWS(3)) dut (
        .clock(clock), .reset(reset), .in_din(in_din), .valid_in(valid_in), .in_sof(in_sof),
        .out_dout(out_dout), .valid_out(valid_out), .out_col(out_col), .out_eol(out_eol)
    );

    multi_line_buffer #(.WIDTH(8), .IMG_WIDTH(1), .ROWS(2)) dut_narrow (
        .clock(clock), .reset(reset), .in_din(b_din), .valid_in(b_valid), .in_sof(b_sof),
        .out_dout(b_dout), .valid_out(b_vout), .out_col(b_col), .out_eol(b_eol)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic pix_col_t col3(input int oldest, input int mid, input int newest);
        pix_col_t c;
        c[2] = 8'(oldest);
        c[1] = 8'(mid);
        c[0] = 8'(newest);
        return c;
    endfunction

    task automatic step(input logic v, input logic [7:0] d, input logic s);
        @(negedge clock);
        valid_in = v;
        in_din   = d;
        in_sof   = s;
        @(posedge clock);
        #1;
    endtask

    task automatic step_b(input logic [7:0] d);
        @(negedge clock);
        b_valid = 1'b1;
        b_din   = d;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input bit v, input pix_col_t exp_col, input int c);
        check({tag, " valid_out"}, 64'(valid_out), 64'(v));
        if (v) check({tag, " out_dout"}, 64'(out_dout), 64'(exp_col));
        check({tag, " out_col"}, 64'(out_col), 64'(c));
        check({tag, " out_eol"}, 64'(out_eol), 64'(c == IMG_WIDTH - 1));
    endtask

    initial begin
        int nv;

        // reset state
        #3 reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst valid_out", 64'(valid_out), 64'(0));
        check("rst out_dout", 64'(out_dout), 64'(0));
        check("rst out_col", 64'(out_col), 64'(0));
        check("rst out_eol", 64'(out_eol), 64'(0));
        check("rst narrow out_eol", 64'(b_eol), 64'(0));
        @(negedge clock);
        reset = 1'b1;

        // IMG_WIDTH=1, ROWS=2: pixels 1,2,3
        step_b(8'd1);
        check("w1 p1 valid_out", 64'(b_vout), 64'(0));
        check("w1 p1 out_eol", 64'(b_eol), 64'(1));
        step_b(8'd2);
        check("w1 p2 valid_out", 64'(b_vout), 64'(1));
        check("w1 p2 out_dout", 64'(b_dout), 64'(16'h0102));
        check("w1 p2 out_col", 64'(b_col), 64'(0));
        check("w1 p2 out_eol", 64'(b_eol), 64'(1));
        step_b(8'd3);
        check("w1 p3 valid_out", 64'(b_vout), 64'(1));
        check("w1 p3 out_dout", 64'(b_dout), 64'(16'h0203));
        @(negedge clock);
        b_valid = 1'b0;

        // 18 back-to-back pixels
        nv = 0;
        for (int p = 0; p < 18; p++) begin
            step(1'b1, 8'(p), p == 0);
            nv += int'(valid_out);
            chk($sformatf("burst p%0d", p), p >= 12, col3(p - 12, p - 6, p), p % 6);
        end
        check("burst valid count", 64'(nv), 64'(6));

        // same stream with idle cycles carrying a stray sof
        nv = 0;
        for (int p = 0; p < 18; p++) begin
            step(1'b1, 8'(p), p == 0);
            nv += int'(valid_out);
            chk($sformatf("gap p%0d", p), p >= 12, col3(p - 12, p - 6, p), p % 6);
            step(1'b0, 8'hEE, 1'b1);
            nv += int'(valid_out);
            check($sformatf("gap idle%0d valid_out", p), 64'(valid_out), 64'(0));
            check($sformatf("gap idle%0d out_col", p), 64'(out_col), 64'(p % 6));
            if (p >= 12)
                check($sformatf("gap idle%0d out_dout", p), 64'(out_dout), 64'(col3(p - 12, p - 6, p)));
        end
        check("gap valid count", 64'(nv), 64'(6));

        // frame restart mid-line
        for (int p = 0; p < 15; p++) begin
            step(1'b1, 8'(p), p == 0);
            chk($sformatf("pre p%0d", p), p >= 12, col3(p - 12, p - 6, p), p % 6);
        end
        for (int i = 0; i < 18; i++) begin
            step(1'b1, 8'(100 + i), i == 0);
            chk($sformatf("sof i%0d", i), i >= 12, col3(88 + i, 94 + i, 100 + i), i % 6);
        end

        // asynchronous reset during pixel 8
        for (int p = 0; p < 8; p++) step(1'b1, 8'(p), p == 0);
        @(negedge clock);
        in_din = 8'd8;
        in_sof = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("async valid_out", 64'(valid_out), 64'(0));
        check("async out_dout", 64'(out_dout), 64'(0));
        check("async out_col", 64'(out_col), 64'(0));
        check("async out_eol", 64'(out_eol), 64'(0));
        @(negedge clock);
        reset = 1'b1;
        valid_in = 1'b0;
        for (int i = 0; i < 13; i++) begin
            step(1'b1, 8'(200 + i), 1'b0);
            chk($sformatf("post-rst i%0d", i), i >= 12, col3(188 + i, 194 + i, 200 + i), i % 6);
        end

        // 10-line frame, pixel = row*16+col
        for (int r = 0; r < 10; r++) begin
            for (int c = 0; c < 6; c++) begin
                step(1'b1, 8'(r * 16 + c), (r == 0) && (c == 0));
                chk($sformatf("frame r%0d c%0d", r, c), r >= 2,
                    col3((r - 2) * 16 + c, (r - 1) * 16 + c, r * 16 + c), c);
            end
        end
        @(negedge clock);
        valid_in = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
